// File: rtl/byte_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// byte_pkg: shared definitions for the byte deserializer.
//   DEFAULT_WIDTH : default parallel word width in bits.
//   state_t       : deserializer FSM state encoding (IDLE, SHIFT).
// -----------------------------------------------------------------------------
package byte_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/byte_deserializer_if.sv
// -----------------------------------------------------------------------------
// byte_deserializer_if: serial input and parallel output bus of the
// byte deserializer.
//   sin, sin_valid, sof : serial bit, its qualifier, start-of-word marker
//   dout, dout_valid    : assembled word and its valid flag
//   dout_ready          : downstream acceptance
// Modports:
//   master : the side that drives serial bits and consumes words
//   slave  : the deserializer itself
// -----------------------------------------------------------------------------
interface byte_deserializer_if
  import byte_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output sin, sin_valid, sof, dout_ready,
    input  dout, dout_valid
  );

  modport slave (
    input  sin, sin_valid, sof, dout_ready,
    output dout, dout_valid
  );

endinterface

// File: rtl/byte_deserializer_hold_reg.sv
// -----------------------------------------------------------------------------
// deser_hold_reg: WIDTH-bit output holding register with valid/ready
// handshake and overrun detection.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : a completed word is presented on i_word this cycle
//   i_word       : completed word
//   i_ready      : downstream accepts o_dout when o_valid is high
//   o_dout       : held word (stable while o_valid=1 and i_ready=0)
//   o_valid      : o_dout holds an unconsumed word
//   o_overrun    : one-cycle pulse, a completed word was dropped
// -----------------------------------------------------------------------------
module deser_hold_reg
  import byte_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;

  // Word hold register, valid flag and overrun pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        // Room exists if empty or the held word is being consumed now,
        // which gives back-to-back words without a bubble.
        if (!r_valid || i_ready) begin
          r_dout  <= i_word;
          r_valid <= 1'b1;
        end else begin
          // Old word is kept untouched; the new one is lost.
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign o_dout    = r_dout;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/byte_deserializer.sv
// -----------------------------------------------------------------------------
// byte_deserializer: assembles WIDTH serial bits into a parallel word.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : byte_deserializer_if slave (sin/sin_valid/sof in,
//                  dout/dout_valid out, dout_ready in)
//   o_busy       : a word is partially assembled
//   o_overrun    : one-cycle pulse, a completed word was dropped
//   o_frame_err  : one-cycle pulse, a partial word was aborted by sof
// MSB_FIRST=1 puts the first serial bit in dout[WIDTH-1], 0 in dout[0].
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module byte_deserializer
  import byte_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  byte_deserializer_if.slave  bus,
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_frame_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;
  logic             w_complete;
  logic             w_frame_err;
  logic             r_frame_err;
  logic [WIDTH-1:0] w_dout;
  logic             w_dout_valid;

  // Shift register with the current bit inserted; sof restarts from zero.
  always_comb begin
    w_base = bus.sof ? '0 : r_shift;
    if (MSB_FIRST) begin
      w_shifted = {w_base[WIDTH-2:0], bus.sin};
    end else begin
      w_shifted = {bus.sin, w_base[WIDTH-1:1]};
    end
  end

  // FSM next-state, bit count and shift register update.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_complete   = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.sin_valid && bus.sof) begin
          w_shift_next = w_shifted;
          w_cnt_next   = CW'(1);
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.sin_valid) begin
          w_shift_next = w_shifted;
          if (bus.sof) begin
            // Abort the partial word; this bit starts a fresh one.
            w_frame_err = 1'b1;
            w_cnt_next  = CW'(1);
          end else if (r_cnt == LAST_IDX) begin
            w_complete   = 1'b1;
            w_cnt_next   = '0;
            w_state_next = ST_IDLE;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_shift_next = '0;
      end
    endcase
  end

  // State, count, shift register and frame error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shift     <= w_shift_next;
      r_frame_err <= w_frame_err;
    end
  end

  deser_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_complete),
    .i_word    (w_shifted),
    .i_ready   (bus.dout_ready),
    .o_dout    (w_dout),
    .o_valid   (w_dout_valid),
    .o_overrun (o_overrun)
  );

  assign bus.dout       = w_dout;
  assign bus.dout_valid = w_dout_valid;
  assign o_busy         = (r_state == ST_SHIFT);
  assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_byte_deserializer.sv
// -----------------------------------------------------------------------------
// tb_byte_deserializer: directed self-checking bench. Two instances receive
// the same serial stream, one MSB-first and one LSB-first; the LSB-first
// instance is expected to hold the bit-reversed word.
// -----------------------------------------------------------------------------
module tb_byte_deserializer;

  logic clk;
  logic rst;
  logic sin;
  logic sin_valid;
  logic sof;
  logic dout_ready;

  logic m_busy, m_overrun, m_frame_err;
  logic l_busy, l_overrun, l_frame_err;

  int n_checks;
  int n_err;

  byte_deserializer_if #(.WIDTH(8)) bus_m ();
  byte_deserializer_if #(.WIDTH(8)) bus_l ();

  assign bus_m.sin        = sin;
  assign bus_m.sin_valid  = sin_valid;
  assign bus_m.sof        = sof;
  assign bus_m.dout_ready = dout_ready;
  assign bus_l.sin        = sin;
  assign bus_l.sin_valid  = sin_valid;
  assign bus_l.sof        = sof;
  assign bus_l.dout_ready = dout_ready;

  byte_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_m (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus_m.slave),
    .o_busy      (m_busy),
    .o_overrun   (m_overrun),
    .o_frame_err (m_frame_err)
  );

  byte_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_l (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus_l.slave),
    .o_busy      (l_busy),
    .o_overrun   (l_overrun),
    .o_frame_err (l_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks all outputs of both instances; exp_dout is the MSB-first word.
  task automatic chk_all(input string tag, input logic [7:0] exp_dout,
                         input logic exp_valid, input logic exp_busy,
                         input logic exp_ovr, input logic exp_ferr);
    chk({tag, "_m_dout"},  bus_m.dout,       exp_dout);
    chk({tag, "_l_dout"},  bus_l.dout,       rev8(exp_dout));
    chk({tag, "_m_valid"}, {7'd0, bus_m.dout_valid}, {7'd0, exp_valid});
    chk({tag, "_l_valid"}, {7'd0, bus_l.dout_valid}, {7'd0, exp_valid});
    chk({tag, "_m_busy"},  {7'd0, m_busy},      {7'd0, exp_busy});
    chk({tag, "_l_busy"},  {7'd0, l_busy},      {7'd0, exp_busy});
    chk({tag, "_m_ovr"},   {7'd0, m_overrun},   {7'd0, exp_ovr});
    chk({tag, "_l_ovr"},   {7'd0, l_overrun},   {7'd0, exp_ovr});
    chk({tag, "_m_ferr"},  {7'd0, m_frame_err}, {7'd0, exp_ferr});
    chk({tag, "_l_ferr"},  {7'd0, l_frame_err}, {7'd0, exp_ferr});
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    sin       = b;
    sof       = s;
    sin_valid = 1'b1;
  endtask

  task automatic step_idle();
    @(negedge clk);
    sin       = 1'b0;
    sof       = 1'b0;
    sin_valid = 1'b0;
  endtask

  // Sends w MSB first; with gaps, idle cycles follow some bits and busy
  // must hold across them.
  task automatic send_word(input logic [7:0] w, input logic gaps);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], (i == 0));
      if (gaps && i < 7) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          step_idle();
          chk("gap_busy_m", {7'd0, m_busy}, 8'd1);
          chk("gap_busy_l", {7'd0, l_busy}, 8'd1);
        end
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rst        = 1'b1;
    sin        = 1'b1;
    sof        = 1'b1;
    sin_valid  = 1'b1;
    dout_ready = 1'b1;

    // Reset with active inputs, which must be ignored.
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    sin_valid = 1'b0;
    sof       = 1'b0;
    sin       = 1'b0;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // A5, ready high: valid for exactly one cycle, one cycle after bit 8.
    send_word(8'hA5, 1'b0);
    chk_all("a5_pre", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step_idle();
    chk_all("a5_out", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    step_idle();
    chk_all("a5_clr", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stream 1,0,0,0,0,0,0,0: MSB-first 80, LSB-first 01.
    send_word(8'h80, 1'b0);
    step_idle();
    chk_all("b80_out", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b80_l_is_01", bus_l.dout, 8'h01);
    step_idle();

    // Overrun: ready low, second word dropped.
    dout_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    step_idle();
    chk_all("ovr_w1", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0);
    step_idle();
    chk_all("ovr_pulse", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    step_idle();
    chk_all("ovr_end", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    dout_ready = 1'b1;
    step_idle();
    chk_all("ovr_drain", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame error: 5 bits, then sof restarts with 0F.
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    chk_all("ferr_pulse", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    chk_all("ferr_end", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    step_idle();
    chk_all("ferr_word", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    step_idle();

    // Gapped word 96.
    send_word(8'h96, 1'b1);
    step_idle();
    chk_all("gap_word", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    step_idle();

    // Reset mid-word after 4 bits.
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1; sof = 1'b1; sin_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sin = 1'b0; sof = 1'b0; sin_valid = 1'b0;
    chk_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with a word held.
    dout_ready = 1'b0;
    send_word(8'hE7, 1'b0);
    step_idle();
    chk_all("held_e7", 8'hE7, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all("rst_valid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean word after reset.
    dout_ready = 1'b1;
    send_word(8'h5A, 1'b0);
    step_idle();
    chk_all("post_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    step_idle();
    chk_all("post_clr", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
